// File: rtl/cardinal_output_arbiter.sv
// Round-robin output arbiter for one ring link with per-VC staging slots; a grant goes out on the link one cycle later.
// Under backpressure the staged packet is held, that VC is not granted again, and the send is retried two cycles later.
module cardinal_output_arbiter #(
  parameter int PACKET_SIZE = 64,
  parameter int N_REQ       = 2,
  parameter int VC_BIT      = 63
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*PACKET_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]             req_grant,
  output logic                         polarity,
  input  logic                         out_ro,
  output logic                         out_so,
  output logic [PACKET_SIZE-1:0]       out_do
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic                   polarity_q;
  logic [1:0]             slot_full;
  logic [PACKET_SIZE-1:0] slot_data [2];
  logic [PTR_W-1:0]       rr_ptr [2];

  logic                   fill_vc;
  logic                   link_vc;
  logic [N_REQ-1:0]       eligible;
  logic                   grant_any;
  logic [PACKET_SIZE-1:0] win_data;
  logic [PTR_W-1:0]       win_next_ptr;

  assign polarity = polarity_q;
  assign fill_vc  = polarity_q;
  assign link_vc  = ~polarity_q;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] & (req_data[i*PACKET_SIZE + VC_BIT] == fill_vc);
    end
  end

  // Search from the VC's pointer upward, wrapping; first eligible index wins.
  always_comb begin
    int idx;
    int win;
    req_grant    = '0;
    grant_any    = 1'b0;
    win_data     = '0;
    win_next_ptr = '0;
    idx          = 0;
    win          = 0;
    if (!reset && !slot_full[fill_vc]) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_ptr[fill_vc]) + k) % N_REQ;
        if (!grant_any && eligible[idx]) begin
          grant_any = 1'b1;
          win       = idx;
        end
      end
      if (grant_any) begin
        req_grant[win] = 1'b1;
        win_data       = req_data[win*PACKET_SIZE +: PACKET_SIZE];
        win_next_ptr   = PTR_W'((win + 1) % N_REQ);
      end
    end
  end

  assign out_so = ~reset & slot_full[link_vc] & out_ro;
  assign out_do = out_so ? slot_data[link_vc] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_q   <= 1'b0;
      slot_full    <= 2'b00;
      slot_data[0] <= '0;
      slot_data[1] <= '0;
      rr_ptr[0]    <= '0;
      rr_ptr[1]    <= '0;
    end else begin
      polarity_q <= ~polarity_q;
      // Drain and fill always hit different slots, so both can happen at once.
      if (out_so) begin
        slot_full[link_vc] <= 1'b0;
      end
      if (grant_any) begin
        slot_full[fill_vc] <= 1'b1;
        slot_data[fill_vc] <= win_data;
        rr_ptr[fill_vc]    <= win_next_ptr;
      end
    end
  end

endmodule
